uart_rx_ctrl: RTL and testbench

UART receive controller that sequences frame reception from an oversampled tick stream. It consumes the periodic sample strobe produced by the team's baud tick generator and tracks start, data and stop bits with a tick counter. It delivers each received byte over a valid/ready handshake to downstream logic. It sits between the asynchronous serial line and the receive FIFO or command parser.

---
 rtl/uart_rx_ctrl.sv | 155 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchronizes rx, tracks start/data/stop bits on an oversample tick, hands bytes out over valid/ready.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl #(
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                 state;
  logic                   rx_meta, rx_s, rx_q;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   fall, mid_tick, end_tick, accept, stop_bad;

  // NOTE: synchronizer flops reset to the idle line level so leaving reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  assign fall     = rx_q & ~rx_s;
  assign mid_tick = tick && (cnt == HALF_CNT);
  assign end_tick = tick && (cnt == LAST_CNT);
  assign accept   = rx_valid & rx_ready;
  assign busy     = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_err;
  assign stop_bad = ~rx_s | par_err;
`else
  assign stop_bad = ~rx_s;
`endif

  // NOTE: all state here is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (accept) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          if (mid_tick) begin
            cnt     <= '0;
            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
            par_err <= 1'b0;
`endif
            state   <= rx_s ? IDLE : DATA;
          end else if (tick) begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (end_tick) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + BW'(1);
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else if (tick) begin
            cnt <= cnt + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (end_tick) begin
            cnt     <= '0;
            par_err <= ^{shreg, rx_s};
            state   <= STOP;
          end else if (tick) begin
            cnt <= cnt + CW'(1);
          end
        end
`endif

        STOP: begin
          if (end_tick) begin
            cnt   <= '0;
            state <= IDLE;
            if (stop_bad) begin
              frame_err <= 1'b1;
            end else if (!rx_valid || accept) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else if (tick) begin
            cnt <= cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: OVS=16, tick every 4 clk, table of frames plus hand-written corner sequences.
module tb_uart_rx_ctrl;

  localparam int BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
  localparam int SAMPLE_TICKS = 168;
`else
  localparam int SAMPLE_TICKS = 152;
`endif

  logic       clk, reset, tick, rx, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  uart_rx_ctrl #(.OVS(16), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .tick(tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       bad_par;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_fe;
  } vec_t;

  int total = 0, passed = 0;
  int fe_cnt = 0, ov_cnt = 0, val_cnt = 0, both_cnt = 0;
  int fe0, ov0, val0;
  logic aligned;
  vec_t vecs[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int tdiv;
    tdiv = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      tick = (tdiv == 3);
      tdiv = (tdiv + 1) % 4;
    end
  end

  always @(posedge clk) begin
    #2;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_valid) val_cnt++;
    if (frame_err && overrun) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
    @(posedge clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par);
`endif
    drive_bit(stop);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    fe0 = fe_cnt; ov0 = ov_cnt; val0 = val_cnt;
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  initial begin
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 8'h00, 0, 1});
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 8'hA5, 1, 0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 8'h00, 1, 0});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 8'hFF, 1, 0});
    vecs.push_back('{8'h81, 1'b1, 1'b0, 8'h81, 1, 0});
    vecs.push_back('{8'h5A, 1'b0, 1'b0, 8'h81, 0, 1});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b0, 8'h07, 1, 0});
    vecs.push_back('{8'h07, 1'b1, 1'b1, 8'h07, 0, 1});
`endif

    reset = 1'b1; rx = 1'b1; rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // Glitch: 4 ticks low, also measures line-to-busy latency.
    snap();
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("busy_before_edge", busy, 0);
    @(posedge clk); #1;
    check("busy_after_edge", busy, 1);
    repeat (13) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("glitch_busy", busy, 0);
    check("glitch_valid", val_cnt - val0, 0);
    check("glitch_fe", fe_cnt - fe0, 0);

    foreach (vecs[i]) begin
      snap();
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].bad_par);
      settle();
      check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d_valid_cycles", i), val_cnt - val0, vecs[i].exp_valid);
      check($sformatf("vec%0d_frame_err", i), fe_cnt - fe0, vecs[i].exp_fe);
      check($sformatf("vec%0d_overrun", i), ov_cnt - ov0, 0);
      check($sformatf("vec%0d_busy", i), busy, 0);
    end

    // Backpressure: second frame overruns, third is loaded by an accept on its stop tick.
    rx_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1, 1'b0);
    settle();
    check("ovr_first_data", rx_data, 8'h11);
    check("ovr_first_valid", rx_valid, 1);
    check("ovr_first_ov", ov_cnt - ov0, 0);
    send_frame(8'h22, 1'b1, 1'b0);
    settle();
    check("ovr_second_data", rx_data, 8'h11);
    check("ovr_second_valid", rx_valid, 1);
    check("ovr_second_ov", ov_cnt - ov0, 1);
    check("ovr_second_fe", fe_cnt - fe0, 0);

    snap();
    aligned = 1'b0;
    fork
      send_frame(8'h33, 1'b1, 1'b0);
      begin
        int n;
        n = 0;
        for (int c = 0; c < 2000 && !aligned; c++) begin
          @(posedge clk); #2;
          if (busy && tick) begin
            n++;
            if (n == SAMPLE_TICKS) begin
              rx_ready = 1'b1;
              @(posedge clk); #1;
              rx_ready = 1'b0;
              aligned = 1'b1;
            end
          end
        end
      end
    join
    settle();
    check("accept_align_found", aligned, 1);
    check("accept_load_data", rx_data, 8'h33);
    check("accept_load_valid", rx_valid, 1);
    check("accept_load_ov", ov_cnt - ov0, 0);
    rx_ready = 1'b1;
    settle();
    check("drain_valid", rx_valid, 0);

    // Reset in the middle of data bit 3.
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (BIT_CLK * 4 + BIT_CLK / 2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_valid", rx_valid, 0);
        check("midreset_fe", frame_err, 0);
        check("midreset_ov", overrun, 0);
        check("midreset_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
      end
    join
    settle();
    check("after_reset_busy", busy, 0);
    snap();
    send_frame(8'h5A, 1'b1, 1'b0);
    settle();
    check("post_reset_data", rx_data, 8'h5A);
    check("post_reset_valid_cycles", val_cnt - val0, 1);
    check("post_reset_fe", fe_cnt - fe0, 0);
    check("fe_ov_exclusive", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
